// File: rtl/dpram_sc_rd.sv
// Read-side controller for the single-clock dual-port FIFO RAM.
// Owns the read pointer, pops words into a registered valid/ready output stage.
module dpram_sc_rd #(
  parameter int aw = 2,
  parameter int dw = 8
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [aw:0]   wptr,
  input  logic          flush,
  output logic          rd,
  output logic [aw-1:0] ra,
  input  logic [dw-1:0] dq,
  output logic [aw:0]   rptr,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [dw-1:0] o_dat,
  output logic          empty,
  output logic [aw+1:0] level,
  output logic          err
);

  localparam logic [aw:0] DEPTH = (aw+1)'(1) << aw;

  logic [aw:0]   r_rptr;
  logic          r_vld;
  logic [dw-1:0] r_dat;
  logic          r_err;

  logic [aw:0]   w_diff;
  logic          w_empty;
  logic          w_ld;
  logic          w_ovr;

  // Pointer difference wraps modulo 2^(aw+1); equal pointers with equal wrap bit mean empty.
  assign w_diff  = wptr - r_rptr;
  assign w_empty = (w_diff == '0);
  assign w_ld    = !w_empty && (!r_vld || o_rdy) && !flush;
  assign w_ovr   = (w_diff > DEPTH);

  assign rd    = w_ld & rst_n;
  assign ra    = r_rptr[aw-1:0];
  assign rptr  = r_rptr;
  assign o_vld = r_vld;
  assign o_dat = r_dat;
  assign empty = w_empty;
  assign level = {1'b0, w_diff} + {{(aw+1){1'b0}}, r_vld};
  assign err   = r_err;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
      r_vld  <= 1'b0;
      r_dat  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (flush) begin
        r_rptr <= wptr;
        r_vld  <= 1'b0;
      end else if (w_ld) begin
        r_dat  <= dq;
        r_vld  <= 1'b1;
        r_rptr <= r_rptr + (aw+1)'(1);
      end else if (r_vld && o_rdy) begin
        r_vld  <= 1'b0;
      end
      // Sticky overrun flag, independent of flush.
      if (w_ovr) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dpram_sc_rd.sv
// Bench for dpram_sc_rd: bench-side RAM plus a queue-based FIFO model of the reader.
module tb_dpram_sc_rd;
  localparam int AW = 2;
  localparam int DW = 8;

  logic          ck = 0;
  logic          rst_n;
  logic [AW:0]   wptr;
  logic          flush;
  logic          rd;
  logic [AW-1:0] ra;
  logic [DW-1:0] dq;
  logic [AW:0]   rptr;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          empty;
  logic [AW+1:0] level;
  logic          err;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign dq = mem[ra];

  dpram_sc_rd #(.aw(AW), .dw(DW)) dut (
    .ck(ck), .rst_n(rst_n), .wptr(wptr), .flush(flush), .rd(rd), .ra(ra), .dq(dq),
    .rptr(rptr), .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .empty(empty),
    .level(level), .err(err)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: words written but not yet fetched, plus the output register.
  logic [DW-1:0] q[$];
  logic          m_vld;
  logic [DW-1:0] m_dat;
  logic [AW:0]   m_rptr;
  logic          exp_rd, act_rd;

  task automatic do_reset();
    @(negedge ck);
    rst_n = 0; wptr = '0; flush = 0; o_rdy = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    q.delete(); m_vld = 0; m_dat = '0; m_rptr = '0;
    @(negedge ck);
    rst_n = 1;
  endtask

  // One clock: called at negedge, returns at the next negedge.
  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rdy, input bit fl);
    bit ld;
    o_rdy = rdy; flush = fl;
    #1;
    ld = (q.size() != 0) && (!m_vld || rdy) && !fl;
    exp_rd = ld; act_rd = rd;
    @(posedge ck);
    if (fl) begin q.delete(); m_vld = 0; m_rptr = wptr; end
    else if (ld) begin m_dat = q.pop_front(); m_vld = 1; m_rptr = m_rptr + 1'b1; end
    else if (m_vld && rdy) m_vld = 0;
    #1;
    if (wr) begin mem[wptr[AW-1:0]] = d; q.push_back(d); wptr = wptr + 1'b1; end
    @(negedge ck);
  endtask

  task automatic test_reset();
    @(negedge ck);
    rst_n = 0; wptr = 3'd3; o_rdy = 0; flush = 0;
    #2;
    n_checks++; if (rptr !== 3'd0) begin n_err++; $display("FAIL reset_rptr: got %0h exp 0", rptr); end
    n_checks++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0b exp 0", o_vld); end
    n_checks++; if (o_dat !== 8'h00) begin n_err++; $display("FAIL reset_dat: got %0h exp 0", o_dat); end
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b exp 0", err); end
    n_checks++; if (rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %0b exp 0", rd); end
    @(negedge ck);
    n_checks++; if (rptr !== 3'd0) begin n_err++; $display("FAIL reset_hold_rptr: got %0h exp 0", rptr); end
  endtask

  task automatic test_single();
    do_reset();
    mem[0] = 8'h00;
    cycle(1, 8'hA5, 1, 0);
    n_checks++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL single_lat: got vld %0b exp 0", o_vld); end
    cycle(0, 0, 1, 0);
    n_checks++; if (act_rd !== 1'b1) begin n_err++; $display("FAIL single_rd: got %0b exp 1", act_rd); end
    n_checks++; if (o_vld !== 1'b1 || o_dat !== 8'hA5) begin n_err++; $display("FAIL single_data: got vld %0b dat %0h exp 1 a5", o_vld, o_dat); end
    n_checks++; if (rptr !== 3'd1 || empty !== 1'b1) begin n_err++; $display("FAIL single_ptr: got rptr %0h empty %0b exp 1 1", rptr, empty); end
    cycle(0, 0, 1, 0);
    n_checks++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL single_drain: got vld %0b exp 0", o_vld); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_w [0:3];
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, exp_w[i], 0, 0);
    n_checks++; if (wptr !== 3'd4 || level !== 4'd4) begin n_err++; $display("FAIL wrap_full: got level %0d exp 4", level); end
    n_checks++; if (o_vld !== 1'b1 || o_dat !== 8'h11 || rptr !== 3'd1) begin n_err++; $display("FAIL wrap_first: got vld %0b dat %0h rptr %0h exp 1 11 1", o_vld, o_dat, rptr); end
    for (int i = 1; i < 4; i++) begin
      cycle(0, 0, 1, 0);
      n_checks++; if (o_vld !== 1'b1 || o_dat !== exp_w[i]) begin n_err++; $display("FAIL wrap_stream%0d: got %0h exp %0h", i, o_dat, exp_w[i]); end
    end
    n_checks++; if (rptr !== 3'd4 || empty !== 1'b1) begin n_err++; $display("FAIL wrap_ptr: got rptr %0h empty %0b exp 4 1", rptr, empty); end
    cycle(0, 0, 1, 0);
    n_checks++; if (level !== 4'd0 || o_vld !== 1'b0) begin n_err++; $display("FAIL wrap_level: got level %0d vld %0b exp 0 0", level, o_vld); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle(1, 8'h55, 0, 0);
    cycle(1, 8'h66, 0, 0);
    cycle(1, 8'h77, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      n_checks++; if (o_dat !== 8'h55 || o_vld !== 1'b1 || rptr !== 3'd1 || act_rd !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d: got dat %0h vld %0b rptr %0h rd %0b exp 55 1 1 0", i, o_dat, o_vld, rptr, act_rd); end
    end
    cycle(0, 0, 1, 0);
    n_checks++; if (o_dat !== 8'h66 || act_rd !== 1'b1) begin n_err++; $display("FAIL bp_release1: got %0h rd %0b exp 66 1", o_dat, act_rd); end
    cycle(0, 0, 1, 0);
    n_checks++; if (o_dat !== 8'h77 || rptr !== 3'd3) begin n_err++; $display("FAIL bp_release2: got %0h rptr %0h exp 77 3", o_dat, rptr); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 8'hC1, 0, 0);
    cycle(1, 8'hC2, 0, 0);
    cycle(1, 8'hC3, 0, 0);
    n_checks++; if (level !== 4'd3 || o_vld !== 1'b1) begin n_err++; $display("FAIL flush_pre: got level %0d vld %0b exp 3 1", level, o_vld); end
    cycle(0, 0, 1, 1);
    n_checks++; if (act_rd !== 1'b0) begin n_err++; $display("FAIL flush_rd: got %0b exp 0", act_rd); end
    n_checks++; if (rptr !== 3'd3 || o_vld !== 1'b0 || level !== 4'd0 || empty !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL flush_post: got rptr %0h vld %0b level %0d empty %0b err %0b exp 3 0 0 1 0", rptr, o_vld, level, empty, err); end
  endtask

  task automatic test_random();
    bit wr, rdy, fl;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wr  = ($urandom_range(0, 99) < 60) && (q.size() < (1<<AW));
      rdy = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 99) < 3);
      cycle(wr, DW'($urandom), rdy, fl);
      n_checks++; if (act_rd !== exp_rd) begin n_err++; $display("FAIL rnd_rd c%0d: got %0b exp %0b", c, act_rd, exp_rd); end
      n_checks++; if (o_vld !== m_vld || (m_vld && o_dat !== m_dat)) begin n_err++; $display("FAIL rnd_out c%0d: got %0b/%0h exp %0b/%0h", c, o_vld, o_dat, m_vld, m_dat); end
      n_checks++; if (rptr !== m_rptr) begin n_err++; $display("FAIL rnd_rptr c%0d: got %0h exp %0h", c, rptr, m_rptr); end
      n_checks++; if (level !== 4'(q.size() + int'(m_vld)) || empty !== (q.size() == 0)) begin
        n_err++; $display("FAIL rnd_level c%0d: got %0d/%0b exp %0d/%0b", c, level, empty, q.size() + int'(m_vld), q.size() == 0); end
      n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err c%0d: got %0b exp 0", c, err); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    wptr = 3'd5; flush = 1; o_rdy = 1;
    @(negedge ck);
    flush = 0;
    n_checks++; if (err !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b exp 1", err); end
    n_checks++; if (rptr !== 3'd5) begin n_err++; $display("FAIL ovr_flush_ptr: got %0h exp 5", rptr); end
    repeat (3) @(negedge ck);
    n_checks++; if (err !== 1'b1 || empty !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got err %0b empty %0b exp 1 1", err, empty); end
    rst_n = 0; wptr = '0;
    #2;
    n_checks++; if (err !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b exp 0", err); end
    @(negedge ck);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; wptr = '0; flush = 0; o_rdy = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_flush();
    test_random();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
